// File: rtl/hvac_pkg.sv
// hvac_pkg: shared mode codes, state encodings and defaults
// for the hvac_actuator relay controller.
package hvac_pkg;

  localparam int TEMP_W_DEF = 8;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_HEAT = 2'b01;
  localparam logic [1:0] MODE_COOL = 2'b10;
  localparam logic [1:0] MODE_AUTO = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEAT_ON = 3'd1;
  localparam logic [2:0] ST_COOL_ON = 3'd2;
  localparam logic [2:0] ST_PURGE   = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hvac_tick_gen.sv
// hvac_tick_gen: divides clk down to a one-clk decision tick
// every TICK_DIV cycles; first tick TICK_DIV clks after reset.
module hvac_tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic Reset,
  output logic Tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // free-running divider; tick registered off the terminal count
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      cnt  <= '0;
      Tick <= 1'b0;
    end else begin
      Tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hvac_actuator.sv
// hvac_actuator: heat/cool/fan relay FSM with hysteresis, min run,
// lockout; HVAC_FAN_PURGE_EN adds a post-run fan-only PURGE state.
module hvac_actuator
  import hvac_pkg::*;
#(
  parameter int TEMP_W      = TEMP_W_DEF,
  parameter int HYST        = 1,
  parameter int TICK_DIV    = 100000000,
  parameter int MIN_RUN     = 60,
  parameter int MIN_OFF     = 120,
  parameter int PURGE_TICKS = 30
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic [1:0]        Mode,
  input  logic [TEMP_W-1:0] Setpoint,
  input  logic [TEMP_W-1:0] CurrentTemp,
  output logic              Heat,
  output logic              Cool,
  output logic              Fan,
  output logic [2:0]        State,
  output logic              Tick
);

  localparam int EW   = TEMP_W + 1;
  localparam int CMAX = max3(MIN_RUN, MIN_OFF, PURGE_TICKS);
  localparam int CW   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;

  localparam logic [CW-1:0] RUN_LIM = CW'(MIN_RUN);
  localparam logic [CW-1:0] OFF_LIM = CW'(MIN_OFF);

`ifdef HVAC_FAN_PURGE_EN
  localparam logic [CW-1:0] PUR_LIM = CW'(PURGE_TICKS);
  localparam logic [2:0]    ST_EXIT = ST_PURGE;
`else
  localparam logic [2:0]    ST_EXIT = ST_LOCKOUT;
`endif

  function automatic logic [CW-1:0] sat_inc(
    input logic [CW-1:0] c,
    input logic [CW-1:0] lim
  );
    return (c >= lim) ? lim : c + CW'(1);
  endfunction

  logic          tick;
  logic          heat_mode, cool_mode;
  logic          heat_req, cool_req;
  logic [EW-1:0] cur_e, set_e, hyst_e;
  logic [2:0]    st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] run_nxt, off_nxt;

  hvac_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .Reset (Reset),
    .Tick  (tick)
  );

  assign Tick  = tick;
  assign State = st;

  assign cur_e  = {1'b0, CurrentTemp};
  assign set_e  = {1'b0, Setpoint};
  assign hyst_e = EW'(HYST);

  assign heat_mode = (Mode == MODE_HEAT) || (Mode == MODE_AUTO);
  assign cool_mode = (Mode == MODE_COOL) || (Mode == MODE_AUTO);

  assign heat_req = heat_mode && Enable && (cur_e + hyst_e < set_e);
  assign cool_req = cool_mode && Enable && (cur_e > set_e + hyst_e);

  assign run_nxt = sat_inc(cnt, RUN_LIM);
  assign off_nxt = sat_inc(cnt, OFF_LIM);

  // next state and phase counter, evaluated only on decision ticks
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    if (tick) begin
      unique case (1'b1)
        (st == ST_IDLE): begin
          if (heat_req) begin
            st_n  = ST_HEAT_ON;
            cnt_n = '0;
          end else if (cool_req) begin
            st_n  = ST_COOL_ON;
            cnt_n = '0;
          end
        end
        (st == ST_HEAT_ON): begin
          if (!Enable || !heat_mode ||
              (run_nxt == RUN_LIM && cur_e >= set_e)) begin
            st_n  = ST_EXIT;
            cnt_n = '0;
          end else begin
            cnt_n = run_nxt;
          end
        end
        (st == ST_COOL_ON): begin
          if (!Enable || !cool_mode ||
              (run_nxt == RUN_LIM && cur_e <= set_e)) begin
            st_n  = ST_EXIT;
            cnt_n = '0;
          end else begin
            cnt_n = run_nxt;
          end
        end
`ifdef HVAC_FAN_PURGE_EN
        (st == ST_PURGE): begin
          if (sat_inc(cnt, PUR_LIM) == PUR_LIM) begin
            st_n  = ST_LOCKOUT;
            cnt_n = '0;
          end else begin
            cnt_n = sat_inc(cnt, PUR_LIM);
          end
        end
`endif
        (st == ST_LOCKOUT): begin
          if (off_nxt == OFF_LIM) begin
            st_n  = ST_IDLE;
            cnt_n = '0;
          end else begin
            cnt_n = off_nxt;
          end
        end
        default: begin
          st_n  = ST_IDLE;
          cnt_n = '0;
        end
      endcase
    end
  end

  // state, counter and relay registers; reset drops relays at once
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      st   <= ST_IDLE;
      cnt  <= '0;
      Heat <= 1'b0;
      Cool <= 1'b0;
      Fan  <= 1'b0;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      Heat <= (st_n == ST_HEAT_ON);
      Cool <= (st_n == ST_COOL_ON);
`ifdef HVAC_FAN_PURGE_EN
      Fan  <= (st_n == ST_HEAT_ON) || (st_n == ST_COOL_ON) ||
              (st_n == ST_PURGE);
`else
      Fan  <= (st_n == ST_HEAT_ON) || (st_n == ST_COOL_ON);
`endif
    end
  end

endmodule
